// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply stream driver: word geometry,
// job-size defaults and the one-hot FSM encoding.
package mm_pkg;

    localparam int LANES  = 5;
    localparam int LANE_W = 8;
    localparam int ACC_W  = 16;
    localparam int WORD_W = LANES * LANE_W;
    localparam int RES_W  = LANES * ACC_W;

    localparam int N_DEF   = 5;
    localparam int T_DEF   = 10;
    localparam int TMO_DEF = 64;

    localparam int IDX_W     = 4;
    localparam int TMO_CNT_W = 7;

    localparam logic [7:0] ST_IDLE     = 8'b0000_0001;
    localparam logic [7:0] ST_SEND_W   = 8'b0000_0010;
    localparam logic [7:0] ST_W_TERM   = 8'b0000_0100;
    localparam logic [7:0] ST_SEND_IN  = 8'b0000_1000;
    localparam logic [7:0] ST_IN_TERM  = 8'b0001_0000;
    localparam logic [7:0] ST_WAIT_VAL = 8'b0010_0000;
    localparam logic [7:0] ST_COLLECT  = 8'b0100_0000;
    localparam logic [7:0] ST_DONE     = 8'b1000_0000;

    typedef enum logic {
        SEL_WEIGHT = 1'b0,
        SEL_INPUT  = 1'b1
    } mem_sel_t;

    // DONE is deliberately treated like IDLE for host access and job starts.
    function automatic logic host_access(input logic [7:0] s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/mm_word_mem.sv
// Small word memory: one synchronous write port, one combinational read port.
// Addresses at or beyond DEPTH are ignored on write and read back as zero.
module mm_word_mem #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 40,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Sized to the full address space so the index needs no truncation;
    // entries at DEPTH and above are never written.
    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge CLK) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/mm_stream_driver.sv
// Job controller that streams staged weight and input words to a systolic
// array, then collects the array's result words into a readable buffer.
module mm_stream_driver
    import mm_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int T   = T_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    output logic [WORD_W-1:0] Weight_o,
    output logic [WORD_W-1:0] In_o,
    input  logic [RES_W-1:0]  OUT_i,
    input  logic              VAL_i,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [RES_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [IDX_W-1:0]     W_LAST   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]     IN_LAST  = IDX_W'(T - 1);
    localparam logic [IDX_W-1:0]     RES_LAST = IDX_W'(T - 2);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO - 1);

    logic [7:0]           state;
    logic [7:0]           state_nx;
    logic [IDX_W-1:0]     idx;
    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic                 val_q;
    logic [N-1:0]         w_nz;
    logic [T-1:0]         in_nz;

    logic                 host_ok;
    logic                 w_we;
    logic                 in_we;
    logic                 all_nz;
    logic                 start_ok;
    logic                 start_rej;
    logic                 val_rise;
    logic                 timeout;
    logic                 res_we;
    logic [IDX_W-1:0]     res_waddr;
    logic [WORD_W-1:0]    w_rdata;
    logic [WORD_W-1:0]    in_rdata;

    assign host_ok   = host_access(state);
    assign w_we      = wr_en && host_ok && (wr_sel == SEL_WEIGHT) && (int'(wr_addr) < N);
    assign in_we     = wr_en && host_ok && (wr_sel == SEL_INPUT)  && (int'(wr_addr) < T);
    assign all_nz    = (&w_nz) && (&in_nz);
    assign start_ok  = start && host_ok && all_nz;
    assign start_rej = start && host_ok && !all_nz;
    // val_q follows VAL_i in every state, so a level already high on entry
    // to WAIT_VAL is never mistaken for a rising edge.
    assign val_rise  = VAL_i && !val_q;
    assign timeout   = (state == ST_WAIT_VAL) && !val_rise && (tmo_cnt == TMO_LAST);

    assign busy = !host_ok;

    assign Weight_o = (state == ST_SEND_W)  ? w_rdata  : '0;
    assign In_o     = (state == ST_SEND_IN) ? in_rdata : '0;

    // Result word 0 is captured on the VAL_i edge itself; COLLECT fills 1..T-1.
    assign res_we    = ((state == ST_WAIT_VAL) && val_rise) || (state == ST_COLLECT);
    assign res_waddr = (state == ST_COLLECT) ? idx + IDX_W'(1) : '0;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) state_nx = ST_SEND_W;
            end
            ST_SEND_W: begin
                if (idx == W_LAST) state_nx = ST_W_TERM;
            end
            ST_W_TERM: begin
                state_nx = ST_SEND_IN;
            end
            ST_SEND_IN: begin
                if (idx == IN_LAST) state_nx = ST_IN_TERM;
            end
            ST_IN_TERM: begin
                state_nx = ST_WAIT_VAL;
            end
            ST_WAIT_VAL: begin
                if (val_rise)     state_nx = (T == 1) ? ST_DONE : ST_COLLECT;
                else if (timeout) state_nx = ST_DONE;
            end
            ST_COLLECT: begin
                if (idx == RES_LAST) state_nx = ST_DONE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= ST_IDLE;
            idx     <= '0;
            tmo_cnt <= '0;
            val_q   <= 1'b0;
            done    <= 1'b0;
            err     <= '0;
            w_nz    <= '0;
            in_nz   <= '0;
        end else begin
            state <= state_nx;
            val_q <= VAL_i;
            done  <= ((state_nx == ST_DONE) && (state != ST_DONE)) || start_rej;

            if (state_nx != state) begin
                idx <= '0;
            end else if ((state == ST_SEND_W) || (state == ST_SEND_IN) || (state == ST_COLLECT)) begin
                idx <= idx + IDX_W'(1);
            end

            if ((state == ST_WAIT_VAL) && (state_nx == ST_WAIT_VAL)) begin
                tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (start_ok) begin
                err <= '0;
            end else begin
                if (start_rej) err[0] <= 1'b1;
                if (timeout)   err[1] <= 1'b1;
            end

            for (int i = 0; i < N; i++) begin
                if (w_we && (wr_addr == IDX_W'(i))) w_nz[i] <= |wr_data;
            end
            for (int i = 0; i < T; i++) begin
                if (in_we && (wr_addr == IDX_W'(i))) in_nz[i] <= |wr_data;
            end
        end
    end

    mm_word_mem #(.DEPTH(N), .WIDTH(WORD_W), .AW(IDX_W)) u_weight_mem (
        .CLK   (CLK),
        .we    (w_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx),
        .rdata (w_rdata)
    );

    mm_word_mem #(.DEPTH(T), .WIDTH(WORD_W), .AW(IDX_W)) u_input_mem (
        .CLK   (CLK),
        .we    (in_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx),
        .rdata (in_rdata)
    );

    mm_word_mem #(.DEPTH(T), .WIDTH(RES_W), .AW(IDX_W)) u_result_mem (
        .CLK   (CLK),
        .we    (res_we),
        .waddr (res_waddr),
        .wdata (OUT_i),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mm_stream_driver.sv
// Directed-plus-random bench for mm_stream_driver with a behavioural job model
// (staging arrays, nonzero flags, result buffer and status) kept in the bench.
module tb_mm_stream_driver;

    localparam int N   = 5;
    localparam int T   = 10;
    localparam int TMO = 64;

    logic        CLK;
    logic        RSTN;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [39:0] wr_data;
    logic        start;
    logic [39:0] Weight_o;
    logic [39:0] In_o;
    logic [79:0] OUT_i;
    logic        VAL_i;
    logic [3:0]  rd_addr;
    logic [79:0] rd_data;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    logic [39:0] m_w   [N];
    logic [39:0] m_in  [T];
    bit          m_wnz [N];
    bit          m_innz[T];
    logic [79:0] m_res [T];
    logic [1:0]  m_err;

    mm_stream_driver #(.N(N), .T(T), .TMO(TMO)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .Weight_o (Weight_o),
        .In_o     (In_o),
        .OUT_i    (OUT_i),
        .VAL_i    (VAL_i),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_all_nz();
        bit ok = 1'b1;
        for (int i = 0; i < N; i++) ok &= m_wnz[i];
        for (int i = 0; i < T; i++) ok &= m_innz[i];
        return ok;
    endfunction

    function automatic logic [39:0] rand_word();
        logic [39:0] w = {$urandom, $urandom};
        if (w == 40'h0) w = 40'h1;
        return w;
    endfunction

    // Only called while the driver is idle, so the model applies every in-range write.
    task automatic host_write(input bit sel, input logic [3:0] addr, input logic [39:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
        if (!sel && addr < N) begin
            m_w[addr] = data; m_wnz[addr] = (data != 0);
        end else if (sel && addr < T) begin
            m_in[addr] = data; m_innz[addr] = (data != 0);
        end
    endtask

    task automatic load_all(input bit directed);
        for (int i = 0; i < N; i++) host_write(1'b0, 4'(i), directed ? 40'h0101010101 : rand_word());
        for (int i = 0; i < T; i++) host_write(1'b1, 4'(i), directed ? 40'h0102030405 : rand_word());
    endtask

    task automatic check_results(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk(tag, rd_data, (a < T) ? m_res[a] : 80'h0);
        end
    endtask

    // Runs one accepted job; no_val leaves VAL_i low so the wait times out.
    task automatic run_job(input int delay, input logic [79:0] base, input bit rand_out,
                           input bit no_val, input bit pre_high, input bit disturb);
        logic [79:0] outs[T];
        int n;
        for (int i = 0; i < T; i++)
            outs[i] = rand_out ? {$urandom, $urandom, $urandom} : base + 80'(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_accept_busy", busy, model_all_nz());
        for (int i = 0; i < N; i++) begin
            if (disturb && i == 1) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd4; wr_data = 40'h0;
            end
            chk("weight_word", Weight_o, m_w[i]);
            chk("in_idle_during_w", In_o, 40'h0);
            tick();
            wr_en = 1'b0;
        end
        chk("w_term", Weight_o, 40'h0);
        chk("w_term_busy", busy, 1'b1);
        tick();
        for (int i = 0; i < T; i++) begin
            chk("input_word", In_o, m_in[i]);
            chk("weight_idle_during_in", Weight_o, 40'h0);
            tick();
        end
        chk("in_term", In_o, 40'h0);
        chk("in_term_w", Weight_o, 40'h0);
        chk("in_term_busy", busy, 1'b1);
        if (pre_high) begin
            VAL_i = 1'b1;
            OUT_i = {$urandom, $urandom, $urandom};
        end
        tick();
        if (no_val) begin
            n = 0;
            while (!done && n < TMO + 8) begin
                tick();
                n++;
            end
            chk("timeout_latency", (n >= TMO && n <= TMO + 1), 1'b1);
            m_err = 2'b10;
            chk("timeout_done", done, 1'b1);
            chk("timeout_err", err, m_err);
            chk("timeout_busy", busy, 1'b0);
            tick();
            chk("timeout_done_single", done, 1'b0);
            return;
        end
        if (pre_high) begin
            repeat (3) begin
                chk("prehigh_no_edge_done", done, 1'b0);
                chk("prehigh_no_edge_busy", busy, 1'b1);
                tick();
            end
            VAL_i = 1'b0;
            tick();
        end
        repeat (delay - 1) begin
            chk("wait_done_low", done, 1'b0);
            tick();
        end
        VAL_i = 1'b1;
        for (int i = 0; i < T; i++) begin
            OUT_i = outs[i];
            m_res[i] = outs[i];
            if (disturb && i == 5) start = 1'b1;
            tick();
            start = 1'b0;
        end
        m_err = 2'b00;
        chk("job_done_pulse", done, 1'b1);
        chk("job_done_busy", busy, 1'b0);
        chk("job_err", err, m_err);
        VAL_i = 1'b0;
        OUT_i = '0;
        tick();
        chk("job_done_single", done, 1'b0);
        chk("job_stays_idle", busy, 1'b0);
    endtask

    task automatic reject_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_err[0] = 1'b1;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_busy"}, busy, 1'b0);
        repeat (4) begin
            chk({tag, "_w_zero"}, Weight_o, 40'h0);
            chk({tag, "_in_zero"}, In_o, 40'h0);
            tick();
            chk({tag, "_done_single"}, done, 1'b0);
        end
    endtask

    initial begin
        RSTN = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; OUT_i = '0; VAL_i = 1'b0; rd_addr = '0;
        m_err = 2'b00;
        for (int i = 0; i < N; i++) m_wnz[i] = 1'b0;
        for (int i = 0; i < T; i++) m_innz[i] = 1'b0;
        for (int i = 0; i < T; i++) m_res[i] = 'x;
        #12;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 2'b00);
        chk("reset_w", Weight_o, 40'h0);
        chk("reset_in", In_o, 40'h0);
        RSTN = 1'b1;
        tick();

        $display("[TB] directed job");
        load_all(1'b1);
        run_job(12, 80'h000F_000F_000F_000F_000F, 1'b0, 1'b0, 1'b0, 1'b0);
        check_results("directed_result");

        $display("[TB] random jobs");
        for (int j = 0; j < 3; j++) begin
            load_all(1'b0);
            repeat (3) begin
                host_write(1'b0, 4'(5 + $urandom_range(0, 10)), {$urandom, $urandom});
                host_write(1'b1, 4'(10 + $urandom_range(0, 5)), {$urandom, $urandom});
            end
            run_job($urandom_range(1, 40), '0, 1'b1, 1'b0, (j == 1), (j == 0));
            check_results("random_result");
        end

        $display("[TB] zero-word reject");
        host_write(1'b1, 4'd3, 40'h0);
        reject_start("reject");
        host_write(1'b1, 4'd3, rand_word());

        $display("[TB] result timeout");
        run_job(0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_results("timeout_keeps_result");

        $display("[TB] reset mid-job");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N + 1 + 4) tick();
        chk("mid_in_word4", In_o, m_in[4]);
        RSTN = 1'b0;
        #1;
        chk("abort_in", In_o, 40'h0);
        chk("abort_w", Weight_o, 40'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_err", err, 2'b00);
        #2;
        RSTN = 1'b1;
        m_err = 2'b00;
        for (int i = 0; i < N; i++) m_wnz[i] = 1'b0;
        for (int i = 0; i < T; i++) m_innz[i] = 1'b0;
        tick();
        reject_start("post_reset_reject");
        load_all(1'b0);
        run_job($urandom_range(1, 30), '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_results("post_reset_result");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
